// File: rtl/matmul_gen.sv
// Matrix-multiply engine: Z[MxN] = X[MxK] * Y[KxN], optionally Z += X*Y, over three 1-cycle SRAMs.
// Define MATMUL_SAT_EN to saturate results to the element range; otherwise results wrap.
module matmul_gen #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ACC_WIDTH  = 64,
    parameter int unsigned M          = 8,
    parameter int unsigned K          = 8,
    parameter int unsigned N          = 8,
    localparam int unsigned XA_W      = (M * K > 1) ? $clog2(M * K) : 1,
    localparam int unsigned YA_W      = (K * N > 1) ? $clog2(K * N) : 1,
    localparam int unsigned ZA_W      = (M * N > 1) ? $clog2(M * N) : 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  signed_mode,
    input  logic                  acc_mode,
    output logic                  busy,
    output logic                  done,
    output logic [XA_W-1:0]       x_addr,
    input  logic [DATA_WIDTH-1:0] x_dout,
    output logic [YA_W-1:0]       y_addr,
    input  logic [DATA_WIDTH-1:0] y_dout,
    output logic [ZA_W-1:0]       z_addr,
    input  logic [DATA_WIDTH-1:0] z_dout,
    output logic [DATA_WIDTH-1:0] z_din,
    output logic                  z_wr_en
);

    localparam int unsigned PW = 2 * DATA_WIDTH;
    localparam int unsigned IW = (M > 1) ? $clog2(M) : 1;
    localparam int unsigned JW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned KW = (K > 1) ? $clog2(K) : 1;

    typedef enum logic [1:0] {StIdle, StFetch, StMac, StWrite} state_t;

    state_t                r_state;
    logic [IW-1:0]         r_i;
    logic [JW-1:0]         r_j;
    logic [KW-1:0]         r_k;
    logic [XA_W-1:0]       r_xbase;
    logic [ZA_W-1:0]       r_zidx;
    logic                  r_signed;
    logic                  r_acc_mode;
    logic [ACC_WIDTH-1:0]  r_acc;
    logic                  r_busy;
    logic                  r_done;
    logic [XA_W-1:0]       r_x_addr;
    logic [YA_W-1:0]       r_y_addr;
    logic [ZA_W-1:0]       r_z_addr;
    logic [DATA_WIDTH-1:0] r_z_din;
    logic                  r_z_wr_en;

    logic [PW-1:0]         w_x_ext;
    logic [PW-1:0]         w_y_ext;
    logic [PW-1:0]         w_prod;
    logic [ACC_WIDTH-1:0]  w_prod_ext;
    logic [ACC_WIDTH-1:0]  w_z_ext;
    logic [ACC_WIDTH-1:0]  w_acc_base;
    logic [ACC_WIDTH-1:0]  w_acc_sum;
    logic [DATA_WIDTH-1:0] w_result;
    logic                  w_last_i;
    logic                  w_last_j;
    logic                  w_last_k;
    logic                  w_adv_k;
    logic [JW-1:0]         w_j_nxt;
    logic [XA_W-1:0]       w_xbase_nxt;
    logic [ZA_W-1:0]       w_zidx_nxt;

    // Product of the two 2*DATA_WIDTH extended operands is exact modulo 2^PW in both modes.
    always_comb begin
        if (r_signed) begin
            w_x_ext = PW'($signed(x_dout));
            w_y_ext = PW'($signed(y_dout));
            w_z_ext = ACC_WIDTH'($signed(z_dout));
        end else begin
            w_x_ext = PW'(x_dout);
            w_y_ext = PW'(y_dout);
            w_z_ext = ACC_WIDTH'(z_dout);
        end
        w_prod = w_x_ext * w_y_ext;
        if (r_signed) begin
            w_prod_ext = ACC_WIDTH'($signed(w_prod));
        end else begin
            w_prod_ext = ACC_WIDTH'(w_prod);
        end
        if (r_k == '0) begin
            w_acc_base = r_acc_mode ? w_z_ext : '0;
        end else begin
            w_acc_base = r_acc;
        end
        w_acc_sum = w_acc_base + w_prod_ext;
    end

`ifdef MATMUL_SAT_EN
    logic [ACC_WIDTH-DATA_WIDTH:0]   w_hi_s;
    logic [ACC_WIDTH-DATA_WIDTH-1:0] w_hi_u;

    always_comb begin
        w_hi_s = w_acc_sum[ACC_WIDTH-1:DATA_WIDTH-1];
        w_hi_u = w_acc_sum[ACC_WIDTH-1:DATA_WIDTH];
        w_result = w_acc_sum[DATA_WIDTH-1:0];
        if (r_signed) begin
            if (!((&w_hi_s) || !(|w_hi_s))) begin
                w_result = w_acc_sum[ACC_WIDTH-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                                  : {1'b0, {(DATA_WIDTH-1){1'b1}}};
            end
        end else if (w_acc_sum[ACC_WIDTH-1]) begin
            w_result = '0;
        end else if (|w_hi_u) begin
            w_result = '1;
        end
    end
`else
    assign w_result = w_acc_sum[DATA_WIDTH-1:0];
`endif

    always_comb begin
        w_last_i    = (r_i == IW'(M - 1));
        w_last_j    = (r_j == JW'(N - 1));
        w_last_k    = (r_k == KW'(K - 1));
        // Next MAC cycle presents operand k+2; hold the last valid address past the row end.
        w_adv_k     = (32'(r_k) + 32'd2) < K;
        w_j_nxt     = w_last_j ? '0 : r_j + JW'(1);
        w_xbase_nxt = w_last_j ? r_xbase + XA_W'(K) : r_xbase;
        w_zidx_nxt  = r_zidx + ZA_W'(1);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= StIdle;
            r_i        <= '0;
            r_j        <= '0;
            r_k        <= '0;
            r_xbase    <= '0;
            r_zidx     <= '0;
            r_signed   <= 1'b0;
            r_acc_mode <= 1'b0;
            r_acc      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_x_addr   <= '0;
            r_y_addr   <= '0;
            r_z_addr   <= '0;
            r_z_din    <= '0;
            r_z_wr_en  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    // The done cycle is still the tail of WRITE, so start is refused there.
                    if (start && !r_done) begin
                        r_signed   <= signed_mode;
                        r_acc_mode <= acc_mode;
                        r_i        <= '0;
                        r_j        <= '0;
                        r_k        <= '0;
                        r_xbase    <= '0;
                        r_zidx     <= '0;
                        r_acc      <= '0;
                        r_x_addr   <= '0;
                        r_y_addr   <= '0;
                        r_z_addr   <= '0;
                        r_busy     <= 1'b1;
                        r_state    <= StFetch;
                    end
                end
                StFetch: begin
                    r_k     <= '0;
                    r_state <= StMac;
                    if (K > 1) begin
                        r_x_addr <= r_x_addr + XA_W'(1);
                        r_y_addr <= r_y_addr + YA_W'(N);
                    end
                end
                StMac: begin
                    r_acc <= w_acc_sum;
                    if (w_last_k) begin
                        r_state   <= StWrite;
                        r_x_addr  <= '0;
                        r_y_addr  <= '0;
                        r_z_addr  <= r_zidx;
                        r_z_din   <= w_result;
                        r_z_wr_en <= 1'b1;
                    end else begin
                        r_k <= r_k + KW'(1);
                        if (w_adv_k) begin
                            r_x_addr <= r_x_addr + XA_W'(1);
                            r_y_addr <= r_y_addr + YA_W'(N);
                        end
                    end
                end
                StWrite: begin
                    r_z_wr_en <= 1'b0;
                    r_z_din   <= '0;
                    r_acc     <= '0;
                    r_j       <= w_j_nxt;
                    r_xbase   <= w_xbase_nxt;
                    r_zidx    <= w_zidx_nxt;
                    if (w_last_j) begin
                        r_i <= r_i + IW'(1);
                    end
                    if (w_last_i && w_last_j) begin
                        r_state  <= StIdle;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_x_addr <= '0;
                        r_y_addr <= '0;
                        r_z_addr <= '0;
                    end else begin
                        r_state  <= StFetch;
                        r_x_addr <= w_xbase_nxt;
                        r_y_addr <= YA_W'(w_j_nxt);
                        r_z_addr <= r_acc_mode ? w_zidx_nxt : '0;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign x_addr  = r_x_addr;
    assign y_addr  = r_y_addr;
    assign z_addr  = r_z_addr;
    assign z_din   = r_z_din;
    assign z_wr_en = r_z_wr_en;

endmodule

// File: tb/tb_matmul_gen.sv
// Directed bench for matmul_gen: a default 8x8x8 instance and a 2x3x4, 8-bit instance with SRAM models.
module tb_matmul_gen;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic start_a, start_b, signed_mode, acc_mode;

    logic [5:0]  xa_addr, ya_addr, za_addr;
    logic [31:0] xa_rd, ya_rd, za_rd, za_din;
    logic        za_we, busy_a, done_a;

    logic [2:0]  xb_addr, zb_addr;
    logic [3:0]  yb_addr;
    logic [7:0]  xb_rd, yb_rd, zb_rd, zb_din;
    logic        zb_we, busy_b, done_b;

    matmul_gen u_dut_a (
        .clock      (clk),
        .reset      (rst_n),
        .start      (start_a),
        .signed_mode(signed_mode),
        .acc_mode   (acc_mode),
        .busy       (busy_a),
        .done       (done_a),
        .x_addr     (xa_addr),
        .x_dout     (xa_rd),
        .y_addr     (ya_addr),
        .y_dout     (ya_rd),
        .z_addr     (za_addr),
        .z_dout     (za_rd),
        .z_din      (za_din),
        .z_wr_en    (za_we)
    );

    matmul_gen #(
        .DATA_WIDTH(8),
        .ACC_WIDTH (20),
        .M         (2),
        .K         (3),
        .N         (4)
    ) u_dut_b (
        .clock      (clk),
        .reset      (rst_n),
        .start      (start_b),
        .signed_mode(signed_mode),
        .acc_mode   (acc_mode),
        .busy       (busy_b),
        .done       (done_b),
        .x_addr     (xb_addr),
        .x_dout     (xb_rd),
        .y_addr     (yb_addr),
        .y_dout     (yb_rd),
        .z_addr     (zb_addr),
        .z_dout     (zb_rd),
        .z_din      (zb_din),
        .z_wr_en    (zb_we)
    );

    logic [31:0] xa_mem [64];
    logic [31:0] ya_mem [64];
    logic [31:0] za_mem [64];
    logic [7:0]  xb_mem [8];
    logic [7:0]  yb_mem [16];
    logic [7:0]  zb_mem [8];
    logic        fill_a, fill_b;
    logic [31:0] fill_val;

    always @(posedge clk) begin
        xa_rd <= xa_mem[xa_addr];
        ya_rd <= ya_mem[ya_addr];
        za_rd <= za_mem[za_addr];
        if (fill_a) begin
            for (int e = 0; e < 64; e++) za_mem[e] <= fill_val;
        end else if (za_we) begin
            za_mem[za_addr] <= za_din;
        end
    end

    always @(posedge clk) begin
        xb_rd <= xb_mem[xb_addr];
        yb_rd <= yb_mem[yb_addr];
        zb_rd <= zb_mem[zb_addr];
        if (fill_b) begin
            for (int e = 0; e < 8; e++) zb_mem[e] <= fill_val[7:0];
        end else if (zb_we) begin
            zb_mem[zb_addr] <= zb_din;
        end
    end

    logic       sel;
    logic       mon_done, mon_busy, mon_we;
    logic [7:0] mon_zaddr, mon_xaddr;
    assign mon_done  = sel ? done_b : done_a;
    assign mon_busy  = sel ? busy_b : busy_a;
    assign mon_we    = sel ? zb_we : za_we;
    assign mon_zaddr = sel ? {5'b0, zb_addr} : {2'b0, za_addr};
    assign mon_xaddr = sel ? {5'b0, xb_addr} : {2'b0, xa_addr};

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic fill_z(input bit use_b, input logic [31:0] val);
        fill_val = val;
        if (use_b) fill_b = 1'b1; else fill_a = 1'b1;
        @(posedge clk);
        #1;
        fill_a = 1'b0;
        fill_b = 1'b0;
    endtask

    // X = identity, Y either a ramp (Y[e] = e) or a constant.
    task automatic load_a(input bit ramp, input logic [31:0] yval);
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                xa_mem[r*8+c] = (r == c) ? 32'd1 : 32'd0;
                ya_mem[r*8+c] = ramp ? 32'(r*8+c) : yval;
            end
        end
    endtask

    task automatic check_z_a(input string tag, input bit ramp, input logic [31:0] val);
        for (int e = 0; e < 64; e++)
            check_eq($sformatf("%s z[%0d]", tag, e), za_mem[e], ramp ? 32'(e) : val);
    endtask

    task automatic run_op(input bit use_b, input bit s_mode, input bit a_mode, input int per,
                          input int budget, input int pulse_at, input int rst_at,
                          output int cycles, output int wr_cnt);
        bit was_reset;
        was_reset = 1'b0;
        sel = use_b;
        @(posedge clk);
        #1;
        signed_mode = s_mode;
        acc_mode    = a_mode;
        if (use_b) start_b = 1'b1; else start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        start_b = 1'b0;
        cycles  = 1;
        wr_cnt  = 0;
        while (!mon_done && cycles < budget) begin
            if (mon_we) begin
                check_eq($sformatf("wr_order c%0d", cycles), mon_zaddr, 8'(wr_cnt));
                wr_cnt++;
            end
            if (a_mode && ((cycles - 1) % per) == 0) begin
                check_eq($sformatf("fetch_zaddr c%0d", cycles), mon_zaddr, 8'((cycles - 1) / per));
                check_eq($sformatf("fetch_we c%0d", cycles), mon_we, 1'b0);
            end
            if (cycles == rst_at) begin
                rst_n = 1'b0;
                #1;
                check_eq("rst_busy", mon_busy, 1'b0);
                check_eq("rst_we", mon_we, 1'b0);
                check_eq("rst_done", mon_done, 1'b0);
                check_eq("rst_zaddr", mon_zaddr, 8'd0);
                check_eq("rst_xaddr", mon_xaddr, 8'd0);
                @(posedge clk);
                #1;
                check_eq("rst_hold_we", mon_we, 1'b0);
                rst_n = 1'b1;
                was_reset = 1'b1;
                break;
            end
            if (cycles == pulse_at) begin
                if (use_b) start_b = 1'b1; else start_a = 1'b1;
                signed_mode = ~s_mode;
                acc_mode    = ~a_mode;
            end
            @(posedge clk);
            #1;
            start_a     = 1'b0;
            start_b     = 1'b0;
            signed_mode = s_mode;
            acc_mode    = a_mode;
            cycles++;
        end
        if (!was_reset) check_eq("done_seen", mon_done, 1'b1);
    endtask

    int cyc, wr;

    initial begin
        start_a = 0; start_b = 0; signed_mode = 0; acc_mode = 0;
        sel = 0; fill_a = 0; fill_b = 0; fill_val = 0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_busy", busy_a, 1'b0);
        check_eq("reset_done", done_a, 1'b0);
        check_eq("reset_we", za_we, 1'b0);
        check_eq("reset_addrs", {xa_addr, ya_addr, za_addr}, 18'd0);
        check_eq("reset_zdin", za_din, 32'd0);
        check_eq("reset_busy_b", busy_b, 1'b0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("idle_no_start", busy_a, 1'b0);

        // X = I, Y = ramp: Z copies Y, 641 cycles, 64 writes in address order.
        load_a(1'b1, 32'd0);
        fill_z(1'b0, 32'hDEADBEEF);
        run_op(1'b0, 1'b0, 1'b0, 10, 700, 0, 0, cyc, wr);
        check_eq("t1_cycles", 32'(cyc), 32'd641);
        check_eq("t1_writes", 32'(wr), 32'd64);
        check_z_a("t1", 1'b1, 32'd0);

        // Start pulsed mid-run with flipped modes must be ignored.
        fill_z(1'b0, 32'hDEADBEEF);
        run_op(1'b0, 1'b0, 1'b0, 10, 700, 50, 0, cyc, wr);
        check_eq("t2_cycles", 32'(cyc), 32'd641);
        check_eq("t2_writes", 32'(wr), 32'd64);
        check_z_a("t2", 1'b1, 32'd0);

        // Accumulate: Z = 5 + I*ones = 6.
        load_a(1'b0, 32'd1);
        fill_z(1'b0, 32'd5);
        run_op(1'b0, 1'b0, 1'b1, 10, 700, 0, 0, cyc, wr);
        check_eq("t3_cycles", 32'(cyc), 32'd641);
        check_z_a("t3", 1'b0, 32'd6);

        // Reset during MAC of element 10 (FETCH at cycle 101).
        load_a(1'b1, 32'd0);
        fill_z(1'b0, 32'hA5A5A5A5);
        run_op(1'b0, 1'b0, 1'b0, 10, 700, 0, 105, cyc, wr);
        repeat (3) @(posedge clk);
        #1;
        check_eq("post_rst_idle", busy_a, 1'b0);
        for (int e = 0; e < 10; e++)
            check_eq($sformatf("kept z[%0d]", e), za_mem[e], 32'(e));
        check_eq("no_partial z[10]", za_mem[10], 32'hA5A5A5A5);
        run_op(1'b0, 1'b0, 1'b0, 10, 700, 0, 0, cyc, wr);
        check_eq("t4_cycles", 32'(cyc), 32'd641);
        check_z_a("t4", 1'b1, 32'd0);

        // 2x3x4 signed: (-2)*3 summed over K=3 is -18 = 0xEE.
        for (int e = 0; e < 8; e++) xb_mem[e] = 8'hFE;
        for (int e = 0; e < 16; e++) yb_mem[e] = 8'd3;
        fill_z(1'b1, 32'd0);
        run_op(1'b1, 1'b1, 1'b0, 5, 60, 0, 0, cyc, wr);
        check_eq("t5_cycles", 32'(cyc), 32'd41);
        check_eq("t5_writes", 32'(wr), 32'd8);
        for (int e = 0; e < 8; e++) check_eq($sformatf("t5 z[%0d]", e), zb_mem[e], 8'hEE);

        // Unsigned 0xFF*0xFF over K=3: acc 0x2FA03, clamps to 0xFF or wraps to 0x03.
        for (int e = 0; e < 8; e++) xb_mem[e] = 8'hFF;
        for (int e = 0; e < 16; e++) yb_mem[e] = 8'hFF;
        fill_z(1'b1, 32'd0);
        run_op(1'b1, 1'b0, 1'b0, 5, 60, 0, 0, cyc, wr);
        check_eq("t6_cycles", 32'(cyc), 32'd41);
        for (int e = 0; e < 8; e++) begin
`ifdef MATMUL_SAT_EN
            check_eq($sformatf("t6 z[%0d]", e), zb_mem[e], 8'hFF);
`else
            check_eq($sformatf("t6 z[%0d]", e), zb_mem[e], 8'h03);
`endif
        end

        // Start held from the done cycle: refused there, accepted one cycle later.
        start_b = 1'b1;
        @(posedge clk);
        #1;
        check_eq("start_on_done", busy_b, 1'b0);
        @(posedge clk);
        #1;
        start_b = 1'b0;
        check_eq("start_after_done", busy_b, 1'b1);
        cyc = 0;
        while (!done_b && cyc < 60) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check_eq("rerun_done", done_b, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
